// File: rtl/chess_pkg.sv
// Shared types and constants for the chess board datapath.
package chess_pkg;

  localparam int SQ_W    = 6;
  localparam int PIECE_W = 5;

  localparam logic [PIECE_W-1:0] EMPTY_PIECE = '0;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_SRC,
    ST_RD_DST,
    ST_CHECK,
    ST_WR_DST,
    ST_WR_SRC,
    ST_UNDO_DST,
    ST_UNDO_SRC,
    ST_RESP
  } exec_state_t;

  typedef struct packed {
    logic [SQ_W-1:0]    from_sq;
    logic [SQ_W-1:0]    to_sq;
    logic [PIECE_W-1:0] moved;
    logic [PIECE_W-1:0] captured;
  } move_rec_t;

endpackage

// File: rtl/move_undo_record.sv
// Single-level undo record: holds the last successful move until cleared.
module move_undo_record
  import chess_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      i_load,
  input  logic      i_clear,
  input  move_rec_t i_rec,
  output logic      o_valid,
  output move_rec_t o_rec
);

  move_rec_t r_rec;
  logic      r_valid;

  // Load wins over clear; reset discards the record.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rec   <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_rec   <= i_rec;
      r_valid <= 1'b1;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_rec   = r_rec;

endmodule

// File: rtl/move_executor.sv
// Move sequencer in front of the 64x5 board RAM: read source and
// destination, validate, write destination, clear source, report.
// Optional single-level undo is built when MOVE_EXECUTOR_UNDO_EN is defined.
module move_executor #(
  parameter int SQ_W    = chess_pkg::SQ_W,
  parameter int PIECE_W = chess_pkg::PIECE_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               move_valid,
  output logic               move_ready,
  input  logic [SQ_W-1:0]    from_sq,
  input  logic [SQ_W-1:0]    to_sq,
  input  logic               undo_req,
  output logic               done,
  output logic               error,
  output logic [PIECE_W-1:0] moved_piece,
  output logic [PIECE_W-1:0] captured,
  output logic               ram_en,
  output logic               ram_rw,
  output logic [SQ_W-1:0]    ram_addr,
  output logic [PIECE_W-1:0] ram_wdata,
  input  logic [PIECE_W-1:0] ram_rdata
);

  import chess_pkg::*;

  exec_state_t        r_state, w_next;
  logic [SQ_W-1:0]    r_from, r_to;
  logic [PIECE_W-1:0] r_src_piece, r_dst_piece;

  logic               r_move_ready, r_done, r_error;
  logic [PIECE_W-1:0] r_moved, r_captured;
  logic               r_ram_en, r_ram_rw;
  logic [SQ_W-1:0]    r_ram_addr;
  logic [PIECE_W-1:0] r_ram_wdata;

  logic               w_ram_en, w_ram_rw;
  logic [SQ_W-1:0]    w_ram_addr;
  logic [PIECE_W-1:0] w_ram_wdata;
  logic               w_resp_err, w_resp_upd;
  logic [PIECE_W-1:0] w_resp_moved, w_resp_capt;
  logic               w_move_err;

  assign w_move_err = (r_src_piece == EMPTY_PIECE) || (r_from == r_to);

`ifdef MOVE_EXECUTOR_UNDO_EN
  logic      w_rec_valid, w_rec_load, w_rec_clear;
  move_rec_t w_rec_d, w_rec_q;

  assign w_rec_load  = (r_state == ST_WR_SRC);
  assign w_rec_clear = (r_state == ST_UNDO_SRC);
  assign w_rec_d     = '{from_sq: r_from, to_sq: r_to,
                         moved: r_src_piece, captured: r_dst_piece};

  move_undo_record u_undo_record (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_rec_load),
    .i_clear (w_rec_clear),
    .i_rec   (w_rec_d),
    .o_valid (w_rec_valid),
    .o_rec   (w_rec_q)
  );
`else
  logic w_undo_unused;
  assign w_undo_unused = undo_req;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next state, response values, and the RAM command for the state being
  // entered; the command is registered so it is presented during that state.
  always_comb begin
    w_next       = r_state;
    w_ram_en     = 1'b0;
    w_ram_rw     = 1'b0;
    w_ram_addr   = '0;
    w_ram_wdata  = '0;
    w_resp_err   = 1'b0;
    w_resp_upd   = 1'b0;
    w_resp_moved = r_src_piece;
    w_resp_capt  = r_dst_piece;
    unique case (r_state)
      ST_IDLE: begin
`ifdef MOVE_EXECUTOR_UNDO_EN
        if (undo_req) begin
          if (w_rec_valid) begin
            w_next = ST_UNDO_DST;
          end else begin
            w_next     = ST_RESP;
            w_resp_err = 1'b1;
          end
        end else if (move_valid) begin
          w_next = ST_RD_SRC;
        end
`else
        if (move_valid) w_next = ST_RD_SRC;
`endif
      end
      ST_RD_SRC: w_next = ST_RD_DST;
      ST_RD_DST: w_next = ST_CHECK;
      ST_CHECK: begin
        if (w_move_err) begin
          w_next      = ST_RESP;
          w_resp_err  = 1'b1;
          w_resp_upd  = 1'b1;
          w_resp_capt = ram_rdata;
        end else begin
          w_next = ST_WR_DST;
        end
      end
      ST_WR_DST: w_next = ST_WR_SRC;
      ST_WR_SRC: begin
        w_next     = ST_RESP;
        w_resp_upd = 1'b1;
      end
`ifdef MOVE_EXECUTOR_UNDO_EN
      ST_UNDO_DST: w_next = ST_UNDO_SRC;
      ST_UNDO_SRC: begin
        w_next       = ST_RESP;
        w_resp_upd   = 1'b1;
        w_resp_moved = w_rec_q.moved;
        w_resp_capt  = w_rec_q.captured;
      end
`endif
      default: w_next = ST_IDLE;
    endcase

    unique case (w_next)
      ST_RD_SRC: begin
        w_ram_en   = 1'b1;
        w_ram_addr = from_sq;
      end
      ST_RD_DST: begin
        w_ram_en   = 1'b1;
        w_ram_addr = r_to;
      end
      ST_WR_DST: begin
        w_ram_en    = 1'b1;
        w_ram_rw    = 1'b1;
        w_ram_addr  = r_to;
        w_ram_wdata = r_src_piece;
      end
      ST_WR_SRC: begin
        w_ram_en    = 1'b1;
        w_ram_rw    = 1'b1;
        w_ram_addr  = r_from;
        w_ram_wdata = EMPTY_PIECE;
      end
`ifdef MOVE_EXECUTOR_UNDO_EN
      ST_UNDO_DST: begin
        w_ram_en    = 1'b1;
        w_ram_rw    = 1'b1;
        w_ram_addr  = w_rec_q.to_sq;
        w_ram_wdata = w_rec_q.captured;
      end
      ST_UNDO_SRC: begin
        w_ram_en    = 1'b1;
        w_ram_rw    = 1'b1;
        w_ram_addr  = w_rec_q.from_sq;
        w_ram_wdata = w_rec_q.moved;
      end
`endif
      default: ;
    endcase
  end

  // Registered outputs and move datapath latches.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_move_ready <= 1'b1;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_moved      <= '0;
      r_captured   <= '0;
      r_ram_en     <= 1'b0;
      r_ram_rw     <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_wdata  <= '0;
      r_from       <= '0;
      r_to         <= '0;
      r_src_piece  <= '0;
      r_dst_piece  <= '0;
    end else begin
      r_move_ready <= (w_next == ST_IDLE);
      r_done       <= (w_next == ST_RESP);
      r_error      <= w_resp_err;
      r_ram_en     <= w_ram_en;
      r_ram_rw     <= w_ram_rw;
      r_ram_addr   <= w_ram_addr;
      r_ram_wdata  <= w_ram_wdata;
      if (w_resp_upd) begin
        r_moved    <= w_resp_moved;
        r_captured <= w_resp_capt;
      end
      if (r_state == ST_IDLE && w_next == ST_RD_SRC) begin
        r_from <= from_sq;
        r_to   <= to_sq;
      end
      if (r_state == ST_RD_DST) r_src_piece <= ram_rdata;
      if (r_state == ST_CHECK)  r_dst_piece <= ram_rdata;
    end
  end

  assign move_ready  = r_move_ready;
  assign done        = r_done;
  assign error       = r_error;
  assign moved_piece = r_moved;
  assign captured    = r_captured;
  assign ram_en      = r_ram_en;
  assign ram_rw      = r_ram_rw;
  assign ram_addr    = r_ram_addr;
  assign ram_wdata   = r_ram_wdata;

endmodule

// File: tb/tb_move_executor.sv
// Testbench for move_executor with a board RAM model and a board-level
// reference of expected moves, captures and undos.
module tb_move_executor;

  localparam int SQ_W    = 6;
  localparam int PIECE_W = 5;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               move_valid = 1'b0;
  logic               undo_req = 1'b0;
  logic [SQ_W-1:0]    from_sq = '0;
  logic [SQ_W-1:0]    to_sq = '0;
  logic               move_ready, done, error;
  logic [PIECE_W-1:0] moved_piece, captured;
  logic               ram_en, ram_rw;
  logic [SQ_W-1:0]    ram_addr;
  logic [PIECE_W-1:0] ram_wdata;
  logic [PIECE_W-1:0] ram_rdata = '0;

  logic               pre_we = 1'b0;
  logic [SQ_W-1:0]    pre_addr = '0;
  logic [PIECE_W-1:0] pre_data = '0;

  logic [PIECE_W-1:0] mem [64];
  int                 rw_cnt = 0;

  int board [64];
  int rec_from, rec_to, rec_moved, rec_capt;
  bit rec_valid = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  move_executor #(.SQ_W(SQ_W), .PIECE_W(PIECE_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .move_valid  (move_valid),
    .move_ready  (move_ready),
    .from_sq     (from_sq),
    .to_sq       (to_sq),
    .undo_req    (undo_req),
    .done        (done),
    .error       (error),
    .moved_piece (moved_piece),
    .captured    (captured),
    .ram_en      (ram_en),
    .ram_rw      (ram_rw),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata)
  );

  // Board RAM: registered read, write on enable; preload port for the bench.
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (ram_en) begin
      if (ram_rw) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
    if (ram_rw) rw_cnt <= rw_cnt + 1;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int board_diffs();
    int d = 0;
    for (int i = 0; i < 64; i++)
      if (int'(mem[i]) != board[i]) d++;
    return d;
  endfunction

  task automatic set_sq(input int a, input int v);
    @(negedge clk);
    pre_we   = 1'b1;
    pre_addr = 6'(a);
    pre_data = 5'(v);
    @(posedge clk);
    #1 pre_we = 1'b0;
    board[a] = v;
  endtask

  // Called at the negedge of cycle 1; returns the cycle done is seen in.
  task automatic wait_done(output int lat, output int rdy_hi);
    lat = -1;
    rdy_hi = 0;
    for (int c = 1; c <= 20; c++) begin
      if (c > 1) @(negedge clk);
      if (done) begin
        lat = c;
        break;
      end
      if (move_ready) rdy_hi++;
    end
  endtask

  task automatic run_move(input int f, input int t);
    int exp_mv, exp_cp, exp_err, lat, rdy_hi, rw0;
    exp_mv  = board[f];
    exp_cp  = board[t];
    exp_err = (exp_mv == 0 || f == t) ? 1 : 0;
    @(negedge clk);
    from_sq = 6'(f);
    to_sq = 6'(t);
    move_valid = 1'b1;
    check_val("ready_before_move", int'(move_ready), 1);
    rw0 = rw_cnt;
    @(posedge clk);
    @(negedge clk);
    move_valid = 1'b0;
    from_sq = 6'($urandom_range(0, 63));
    to_sq = 6'($urandom_range(0, 63));
    wait_done(lat, rdy_hi);
    check_val("move_latency", lat, exp_err ? 4 : 6);
    check_val("move_error", int'(error), exp_err);
    check_val("move_moved", int'(moved_piece), exp_mv);
    check_val("move_captured", int'(captured), exp_cp);
    check_val("move_ready_busy", rdy_hi, 0);
    check_val("move_writes", rw_cnt - rw0, exp_err ? 0 : 2);
    if (exp_err == 0) begin
      board[t] = exp_mv;
      board[f] = 0;
      rec_from = f; rec_to = t; rec_moved = exp_mv; rec_capt = exp_cp;
      rec_valid = 1'b1;
    end
    @(negedge clk);
    check_val("done_one_cycle", int'(done), 0);
    check_val("move_board", board_diffs(), 0);
  endtask

  task automatic run_undo();
    int lat, rdy_hi, rw0, n_done, n_en, n_busy;
    @(negedge clk);
    undo_req = 1'b1;
    rw0 = rw_cnt;
    @(posedge clk);
    @(negedge clk);
    undo_req = 1'b0;
`ifdef MOVE_EXECUTOR_UNDO_EN
    wait_done(lat, rdy_hi);
    check_val("undo_latency", lat, rec_valid ? 3 : 1);
    check_val("undo_error", int'(error), rec_valid ? 0 : 1);
    check_val("undo_writes", rw_cnt - rw0, rec_valid ? 2 : 0);
    if (rec_valid) begin
      check_val("undo_moved", int'(moved_piece), rec_moved);
      check_val("undo_captured", int'(captured), rec_capt);
      board[rec_to] = rec_capt;
      board[rec_from] = rec_moved;
    end
    rec_valid = 1'b0;
    @(negedge clk);
    check_val("undo_done_one_cycle", int'(done), 0);
`else
    n_done = 0; n_en = 0; n_busy = 0;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      if (done) n_done++;
      if (ram_en) n_en++;
      if (!move_ready) n_busy++;
    end
    check_val("undo_ignored_done", n_done, 0);
    check_val("undo_ignored_ram", n_en + (rw_cnt - rw0), 0);
    check_val("undo_ignored_busy", n_busy, 0);
`endif
    check_val("undo_board", board_diffs(), 0);
  endtask

  task automatic run_move_reset(input int f, input int t);
    int exp_mv, n_done;
    exp_mv = board[f];
    @(negedge clk);
    from_sq = 6'(f);
    to_sq = 6'(t);
    move_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    move_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_in_wr_dst", int'(ram_rw), 1);
    reset = 1'b1;
    @(negedge clk);
    check_val("rst_ready", int'(move_ready), 1);
    check_val("rst_ram_en", int'(ram_en), 0);
    check_val("rst_done", int'(done), 0);
    reset = 1'b0;
    n_done = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check_val("rst_no_done", n_done, 0);
    board[t] = exp_mv;
    rec_valid = 1'b0;
    check_val("rst_board", board_diffs(), 0);
  endtask

  task automatic run_b2b();
    int pf[3], pt[3], acc[3], nacc, lat, rdy_hi;
    bit acc_now;
    pf = '{0, 16, 32};
    pt = '{8, 24, 40};
    acc = '{-100, -100, -100};
    nacc = 0;
    for (int i = 0; i < 3; i++) begin
      set_sq(pf[i], $urandom_range(1, 31));
      set_sq(pt[i], $urandom_range(0, 31));
    end
    @(negedge clk);
    move_valid = 1'b1;
    from_sq = 6'(pf[0]);
    to_sq = 6'(pt[0]);
    for (int c = 0; c < 40 && nacc < 3; c++) begin
      acc_now = move_ready;
      @(posedge clk);
      if (acc_now) begin
        acc[nacc] = c;
        nacc++;
      end
      @(negedge clk);
      if (acc_now && nacc < 3) begin
        from_sq = 6'(pf[nacc]);
        to_sq = 6'(pt[nacc]);
      end
    end
    move_valid = 1'b0;
    check_val("b2b_accepts", nacc, 3);
    check_val("b2b_gap1", acc[1] - acc[0], 7);
    check_val("b2b_gap2", acc[2] - acc[1], 7);
    wait_done(lat, rdy_hi);
    check_val("b2b_last_latency", lat, 6);
    for (int i = 0; i < 3; i++) begin
      rec_from = pf[i]; rec_to = pt[i];
      rec_moved = board[pf[i]]; rec_capt = board[pt[i]];
      board[pt[i]] = board[pf[i]];
      board[pf[i]] = 0;
    end
    rec_valid = 1'b1;
    check_val("b2b_captured", int'(captured), rec_capt);
    @(negedge clk);
    check_val("b2b_board", board_diffs(), 0);
  endtask

  initial begin
    int f, t;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("reset_ready", int'(move_ready), 1);
    check_val("reset_done", int'(done), 0);
    check_val("reset_error", int'(error), 0);
    check_val("reset_moved", int'(moved_piece), 0);
    check_val("reset_captured", int'(captured), 0);
    check_val("reset_ram_en", int'(ram_en), 0);
    check_val("reset_ram_rw", int'(ram_rw), 0);
    check_val("reset_ram_addr", int'(ram_addr), 0);
    check_val("reset_ram_wdata", int'(ram_wdata), 0);
    reset = 1'b0;

    for (int i = 0; i < 64; i++)
      set_sq(i, ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 31)));

    // Quiet move, capture, undo twice.
    set_sq(12, 5);
    set_sq(28, 0);
    run_move(12, 28);
    set_sq(28, 5);
    set_sq(35, 12);
    run_move(28, 35);
    run_undo();
    run_undo();

    // Rejected requests.
    set_sq(20, 0);
    run_move(20, 36);
    run_move(9, 9);

    // Reset during WR_DST after a successful move, then undo.
    set_sq(40, 7);
    run_move(40, 41);
    run_move_reset(41, 44);
    run_undo();

    run_b2b();

    repeat (30) begin
`ifdef MOVE_EXECUTOR_UNDO_EN
      if ($urandom_range(0, 3) == 0) begin
        run_undo();
      end else begin
`else
      begin
`endif
        f = $urandom_range(0, 63);
        t = ($urandom_range(0, 7) == 0) ? f : int'($urandom_range(0, 63));
        run_move(f, t);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
